// File: rtl/spi_regfile_peripheral_if.sv
// ---------------------------------------------------------------------------
// spi_regfile_peripheral_if
// Bundles the SPI pins and the flat register bus of the SPI register-file
// peripheral so they can be passed around as one port.
//
// Signals:
//   COPI, nCS, SCLK     serial data in, chip select (active low), serial clock
//   CIPO, CIPO_oe       serial data out and its output enable
//   regs_flat           all registers, register i at [i*DATA_W +: DATA_W]
//   wr_pulse            one-clk strobe per committed write
//   wr_addr             address of the last committed write
//   frame_abort         one-clk strobe when a frame ends mid-word
//
// Modports:
//   slave   the peripheral side (receives pins, drives the register bus)
//   master  the controller / surrounding-logic side
// ---------------------------------------------------------------------------
interface spi_regfile_peripheral_if #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
);
    logic                         COPI;
    logic                         nCS;
    logic                         SCLK;
    logic                         CIPO;
    logic                         CIPO_oe;
    logic [NUM_REGS*DATA_W-1:0]   regs_flat;
    logic                         wr_pulse;
    logic [ADDR_W-1:0]            wr_addr;
    logic                         frame_abort;

    modport slave (
        input  COPI, nCS, SCLK,
        output CIPO, CIPO_oe, regs_flat, wr_pulse, wr_addr, frame_abort
    );

    modport master (
        output COPI, nCS, SCLK,
        input  CIPO, CIPO_oe, regs_flat, wr_pulse, wr_addr, frame_abort
    );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// ---------------------------------------------------------------------------
// spi_regfile_peripheral
// SPI mode 0/1 peripheral (CPOL = 0) giving an external controller single and
// burst (auto-increment) access to a register file. Frames are MSB first:
// one R/W bit (1 = write), ADDR_W address bits, then DATA_W-bit data words.
// All SPI pins are oversampled in the clk domain.
//
// Ports:
//   clk    system clock, the only clock
//   reset  synchronous, active-low reset
//   bus    slave side of spi_regfile_peripheral_if (SPI pins + register bus)
//
// Parameters:
//   NUM_REGS  implemented registers (1 .. 2**ADDR_W)
//   DATA_W    register / data-word width (>= 2)
//   ADDR_W    address field width (>= 2)
//   CPHA      0: sample on SCLK rise, shift on fall; 1: the reverse
// ---------------------------------------------------------------------------
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int CPHA     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_regfile_peripheral_if.slave bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // Receive shifter only needs to hold the bits preceding the current one.
    localparam int SHW   = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int MAXB  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W = $clog2(MAXB);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        WAIT
    } state_t;

    logic                copiS1_q, copiSync_q;
    logic                ncsS1_q, ncsSync_q;
    logic                sclkS1_q, sclkSync_q, sclkPrev_q;
    logic [1:0]          syncValid_q;
    state_t              state_q;
    logic [CNT_W-1:0]    bitCnt_q;
    logic [SHW-1:0]      rxShift_q;
    logic                isWrite_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   txShift_q;
    logic                cipo_q;
    logic                wrPulse_q;
    logic [ADDR_W-1:0]   wrAddr_q;
    logic                abort_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                sclkRise_d, sclkFall_d, sampleEdge_d, shiftEdge_d;
    logic [ADDR_W:0]     cmdWord_d;
    logic [DATA_W-1:0]   dataWord_d;
    logic [ADDR_W-1:0]   loadAddr_d;
    logic                addrOk_d;
    logic [DATA_W-1:0]   rdWord_d;
    logic                cmdLast_d, dataLast_d;

    // Edge detection on the synchronised SCLK and the words completed by the
    // current sample. On the CMD-completing edge the address to read from is
    // the one just received, not the stale addr_q.
    always_comb begin
        sclkRise_d   = sclkSync_q & ~sclkPrev_q;
        sclkFall_d   = ~sclkSync_q & sclkPrev_q;
        sampleEdge_d = (CPHA == 0) ? sclkRise_d : sclkFall_d;
        shiftEdge_d  = (CPHA == 0) ? sclkFall_d : sclkRise_d;
        cmdWord_d    = {rxShift_q[ADDR_W-1:0], copiSync_q};
        dataWord_d   = {rxShift_q[DATA_W-2:0], copiSync_q};
        cmdLast_d    = (bitCnt_q == CNT_W'(ADDR_W));
        dataLast_d   = (bitCnt_q == CNT_W'(DATA_W - 1));
        loadAddr_d   = (state_q == CMD) ? cmdWord_d[ADDR_W-1:0] : addr_q;
        addrOk_d     = ({1'b0, loadAddr_d} < (ADDR_W + 1)'(NUM_REGS));
        rdWord_d     = addrOk_d ? regs_q[loadAddr_d[IDX_W-1:0]] : '0;
    end

    // Synchronisers, frame FSM, register file and registered outputs.
    // Reset always parks the FSM in WAIT: the synchronisers are cleared to an
    // idle nCS, so only after they have refilled with real pin values
    // (syncValid_q) can a genuinely deasserted nCS release the FSM. This stops
    // a frame that was in flight across reset from being seen as a new one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            copiS1_q    <= 1'b0;
            copiSync_q  <= 1'b0;
            ncsS1_q     <= 1'b1;
            ncsSync_q   <= 1'b1;
            sclkS1_q    <= 1'b0;
            sclkSync_q  <= 1'b0;
            sclkPrev_q  <= 1'b0;
            syncValid_q <= 2'b00;
            state_q     <= WAIT;
            bitCnt_q    <= '0;
            rxShift_q   <= '0;
            isWrite_q   <= 1'b0;
            addr_q      <= '0;
            txShift_q   <= '0;
            cipo_q      <= 1'b0;
            wrPulse_q   <= 1'b0;
            wrAddr_q    <= '0;
            abort_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            copiS1_q    <= bus.COPI;
            copiSync_q  <= copiS1_q;
            ncsS1_q     <= bus.nCS;
            ncsSync_q   <= ncsS1_q;
            sclkS1_q    <= bus.SCLK;
            sclkSync_q  <= sclkS1_q;
            sclkPrev_q  <= sclkSync_q;
            syncValid_q <= {syncValid_q[0], 1'b1};
            wrPulse_q   <= 1'b0;
            abort_q     <= 1'b0;

            if (state_q == WAIT) begin
                cipo_q   <= 1'b0;
                bitCnt_q <= '0;
                if (ncsSync_q && syncValid_q[1]) begin
                    state_q <= IDLE;
                end
            end else if (ncsSync_q) begin
                // Frame ended; only a partially shifted word counts as abort.
                if (state_q != IDLE && bitCnt_q != '0) begin
                    abort_q <= 1'b1;
                end
                state_q  <= IDLE;
                bitCnt_q <= '0;
                cipo_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= CMD;
                        bitCnt_q <= '0;
                    end
                    CMD: begin
                        if (sampleEdge_d) begin
                            rxShift_q <= {rxShift_q[SHW-2:0], copiSync_q};
                            if (cmdLast_d) begin
                                bitCnt_q  <= '0;
                                isWrite_q <= cmdWord_d[ADDR_W];
                                state_q   <= DATA;
                                if (cmdWord_d[ADDR_W]) begin
                                    addr_q <= loadAddr_d;
                                end else begin
                                    txShift_q <= rdWord_d;
                                    addr_q    <= loadAddr_d + 1'b1;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sampleEdge_d) begin
                            rxShift_q <= {rxShift_q[SHW-2:0], copiSync_q};
                            if (dataLast_d) begin
                                bitCnt_q <= '0;
                                addr_q   <= addr_q + 1'b1;
                                if (isWrite_q) begin
                                    if (addrOk_d) begin
                                        regs_q[addr_q[IDX_W-1:0]] <= dataWord_d;
                                        wrPulse_q <= 1'b1;
                                        wrAddr_q  <= addr_q;
                                    end
                                end else begin
                                    // Next word is captured now; later writes
                                    // cannot change what is already loaded.
                                    txShift_q <= rdWord_d;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end else if (shiftEdge_d && !isWrite_q) begin
                            cipo_q    <= txShift_q[DATA_W-1];
                            txShift_q <= {txShift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Flatten the register array onto the bus.
    for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
        assign bus.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign bus.CIPO        = cipo_q;
    assign bus.CIPO_oe     = ~ncsSync_q;
    assign bus.wr_pulse    = wrPulse_q;
    assign bus.wr_addr     = wrAddr_q;
    assign bus.frame_abort = abort_q;

endmodule
